io_ram_serial_tx: RTL and testbench

- Reader on the serial side of the I/O RAM: fetches a block of bytes through one RAM port and transmits them LSB-first as asynchronous 8N1 serial frames on txd.
- Sits between the I/O RAM serial-side port and the board TX pin.
- Mirrors the LZW output-forming logic, which writes results into the same RAM through the other port.

---
 rtl/lzw_io_pkg.sv | 40 ++++
 rtl/io_baud_tick.sv | 38 +++
 rtl/io_ram_serial_tx.sv | 173 +++++++++++++++++
 tb/tb_io_ram_serial_tx.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lzw_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lzw_io_pkg
// Description : Shared constants and state encoding for the LZW I/O RAM
//               serial-side blocks. The PARITY state exists only when
//               IO_RAM_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package lzw_io_pkg;

    localparam int IO_RAM_ADDR_W      = 12;
    localparam int IO_RAM_DEPTH       = 4096;
    localparam int IO_DEFAULT_CLK_DIV = 434;   // 50 MHz / 115200 baud
    localparam int IO_BAUD_CNT_W      = 16;    // holds CLK_DIV-1 up to 65534

`ifdef IO_RAM_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LATCH  = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6,
        ST_FIN    = 3'd7
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LATCH  = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_STOP   = 3'd6,
        ST_FIN    = 3'd7
    } tx_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/io_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : io_baud_tick
// Description : Loadable down-counter producing the bit-end strobe. A load
//               sets the count to CLK_DIV-1; while enabled it counts down and
//               tick is high in the cycle the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module io_baud_tick #(
    parameter int CLK_DIV = 434,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic tick
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    // Reload on request, otherwise count down to zero and stay there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tick = enable && (count == '0);

endmodule
`default_nettype wire

// File: rtl/io_ram_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : io_ram_serial_tx
// Description : Reads byte_len bytes from the I/O RAM starting at start_addr
//               and sends each one LSB-first as an asynchronous 8N1 frame on
//               txd. Addresses wrap modulo the RAM size.
//               Optional macro IO_RAM_TX_PARITY_EN adds an even parity bit
//               (8E1 framing).
// Revision    : 1.0 - initial release
// ============================================================================
module io_ram_serial_tx
    import lzw_io_pkg::*;
#(
    parameter int CLK_DIV = IO_DEFAULT_CLK_DIV,
    parameter int ADDR_W  = IO_RAM_ADDR_W,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   byte_len,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    tx_state_t         state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [DATA_W-1:0] shift_reg;
    logic [2:0]        bit_cnt;
    logic              baud_load;
    logic              baud_enable;
    logic              bit_end;
`ifdef IO_RAM_TX_PARITY_EN
    logic              parity_bit;
`endif

    // Timed states run the baud counter; it is reloaded on entry to every
    // timed state (from LATCH, or at the end of the previous bit).
    always_comb begin
        baud_enable = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
`ifdef IO_RAM_TX_PARITY_EN
        baud_enable = baud_enable || (state == ST_PARITY);
`endif
        baud_load   = (state == ST_LATCH) || bit_end;
    end

    io_baud_tick #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (IO_BAUD_CNT_W)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (baud_load),
        .enable  (baud_enable),
        .tick    (bit_end)
    );

    // Transfer sequencer with registered RAM strobe, serial line and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            txd       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_en    <= 1'b0;
`ifdef IO_RAM_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            done   <= 1'b0;
            ram_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (byte_len != '0) begin
                            addr      <= start_addr;
                            remaining <= byte_len;
                            ram_en    <= 1'b1;
                            state     <= ST_FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end
                    end
                end
                // RAM is enabled during this cycle; data arrives next cycle
                // while the address is held for the RAM output mux.
                ST_FETCH: begin
                    state <= ST_LATCH;
                end
                ST_LATCH: begin
                    shift_reg <= ram_rd_data;
`ifdef IO_RAM_TX_PARITY_EN
                    parity_bit <= ^ram_rd_data;
`endif
                    txd       <= 1'b0;
                    state     <= ST_START;
                end
                ST_START: begin
                    if (bit_end) begin
                        txd     <= shift_reg[0];
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == 3'd7) begin
`ifdef IO_RAM_TX_PARITY_EN
                            txd   <= parity_bit;
                            state <= ST_PARITY;
`else
                            txd   <= 1'b1;
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            txd     <= shift_reg[1];
                        end
                    end
                end
`ifdef IO_RAM_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        txd   <= 1'b1;
                        state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        remaining <= remaining - LEN_ONE;
                        addr      <= addr + ADDR_W'(1);
                        if (remaining == LEN_ONE) begin
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            ram_en <= 1'b1;
                            state  <= ST_FETCH;
                        end
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_addr = addr;
    assign ram_wr   = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_io_ram_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_ram_serial_tx
// Description : Directed self-checking bench for io_ram_serial_tx with
//               CLK_DIV=4. Honours IO_RAM_TX_PARITY_EN for 8E1 framing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_ram_serial_tx;

    localparam int CLK_DIV = 4;
`ifdef IO_RAM_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        start      = 1'b0;
    logic [11:0] start_addr = '0;
    logic [12:0] byte_len   = '0;
    logic        ram_en;
    logic        ram_wr;
    logic [11:0] ram_addr;
    logic [7:0]  ram_rd_data;
    logic        txd;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    io_ram_serial_tx #(
        .CLK_DIV (CLK_DIV),
        .ADDR_W  (12),
        .DATA_W  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .byte_len    (byte_len),
        .ram_en      (ram_en),
        .ram_wr      (ram_wr),
        .ram_addr    (ram_addr),
        .ram_rd_data (ram_rd_data),
        .txd         (txd),
        .busy        (busy),
        .done        (done)
    );

    // RAM model: an 8-byte line is registered on ram_en and the byte is
    // picked with the address bits [2:0] present in the following cycle.
    logic [7:0]  mem [0:4095];
    logic [63:0] line_q = '0;

    always @(posedge clk) begin
        if (ram_en) begin
            for (int i = 0; i < 8; i++) line_q[i*8 +: 8] <= mem[{ram_addr[11:3], 3'(i)}];
        end
    end

    always_comb ram_rd_data = line_q[{ram_addr[2:0], 3'b000} +: 8];

    // Activity monitors.
    int en_cycles   = 0;
    int done_cnt    = 0;
    int low_cycles  = 0;
    int wr_cycles   = 0;
    logic [11:0] last_en_addr = '0;

    always @(negedge clk) begin
        if (ram_en) begin
            en_cycles++;
            last_en_addr = ram_addr;
        end
        if (done)   done_cnt++;
        if (!txd)   low_cycles++;
        if (ram_wr) wr_cycles++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; start is seen by the next posedge (edge k) and the
    // task returns at the negedge of cycle k+1.
    task automatic issue_start(input logic [11:0] a, input logic [12:0] n);
        start      = 1'b1;
        start_addr = a;
        byte_len   = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for a start bit, counting idle-high cycles before it, then
    // samples every cycle of the frame and checks each bit is held steady.
    task automatic get_frame(input string tag, output logic [10:0] bits, output int gap);
        logic found;
        logic stable;
        bits   = '1;
        gap    = 0;
        found  = 1'b0;
        stable = 1'b1;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (txd === 1'b0) found = 1'b1;
            else gap++;
        end
        check({tag, "_found"}, 32'(found), 32'd1);
        if (found) begin
            for (int bi = 0; bi < NBITS; bi++) begin
                for (int s = 0; s < CLK_DIV; s++) begin
                    if (!(bi == 0 && s == 0)) @(negedge clk);
                    if (s == 0) bits[bi] = txd;
                    else if (txd !== bits[bi]) stable = 1'b0;
                end
            end
        end
        check({tag, "_stable"}, 32'(stable), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] bits;
        int          gap;
        int          base_en;
        int          base_done;
        int          base_low;
        logic        seen_low;
`ifdef IO_RAM_TX_PARITY_EN
        logic [10:0] sb_exp = 11'h54A;   // stop,parity=0,0xA5,start
`else
        logic [10:0] sb_exp = 11'h34A;   // stop,0xA5,start
`endif

        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h010] = 8'hA5;
        mem[12'hFFE] = 8'h11;
        mem[12'hFFF] = 8'h22;
        mem[12'h000] = 8'h33;
        mem[12'h020] = 8'h5A;
        mem[12'h021] = 8'hC3;
        mem[12'h030] = 8'hFF;
        mem[12'h040] = 8'h07;
        mem[12'h041] = 8'h03;

        // ---------------- reset values ----------------
        @(negedge clk);
        check("rst_txd",   32'(txd),      32'd1);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);
        check("rst_ram_en",32'(ram_en),   32'd0);
        check("rst_ram_wr",32'(ram_wr),   32'd0);
        check("rst_addr",  32'(ram_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- single byte ----------------
        #1;
        base_en = en_cycles;
        @(negedge clk);
        issue_start(12'h010, 13'd1);
        check("sb_en_k1",   32'(ram_en),   32'd1);
        check("sb_addr_k1", 32'(ram_addr), 32'h010);
        check("sb_busy_k1", 32'(busy),     32'd1);
        @(negedge clk);
        check("sb_en_k2",   32'(ram_en),   32'd0);
        check("sb_addr_k2", 32'(ram_addr), 32'h010);
        check("sb_txd_k2",  32'(txd),      32'd1);
        get_frame("sb", bits, gap);
        check("sb_latency", 32'(gap), 32'd0);
        check("sb_pattern", 32'(bits[NBITS-1:0]), 32'(sb_exp[NBITS-1:0]));
        @(negedge clk);
        check("sb_done",      32'(done), 32'd1);
        check("sb_busy_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("sb_done_off",  32'(done), 32'd0);
        check("sb_busy_off",  32'(busy), 32'd0);
        #1;
        check("sb_en_count", 32'(en_cycles - base_en), 32'd1);

        // ---------------- address wrap ----------------
        @(negedge clk);
        issue_start(12'hFFE, 13'd3);
        get_frame("wr0", bits, gap);
        check("wr0_data", 32'(bits[8:1]), 32'h11);
        check("wr0_stop", 32'(bits[NBITS-1]), 32'd1);
        get_frame("wr1", bits, gap);
        check("wr1_data", 32'(bits[8:1]), 32'h22);
        check("wr1_gap",  32'(gap), 32'd2);
        get_frame("wr2", bits, gap);
        check("wr2_data", 32'(bits[8:1]), 32'h33);
        check("wr2_gap",  32'(gap), 32'd2);
        check("wr2_addr", 32'(ram_addr), 32'h000);
        @(negedge clk);
        check("wr_done", 32'(done), 32'd1);
        @(negedge clk);

        // ---------------- zero length ----------------
        #1;
        base_en  = en_cycles;
        base_low = low_cycles;
        @(negedge clk);
        issue_start(12'h100, 13'd0);
        check("zl_done", 32'(done), 32'd1);
        check("zl_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("zl_done_off", 32'(done), 32'd0);
        check("zl_busy_off", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        #1;
        check("zl_no_ram", 32'(en_cycles - base_en),   32'd0);
        check("zl_no_txd", 32'(low_cycles - base_low), 32'd0);

        // ---------------- start while busy ----------------
        @(negedge clk);
        #1;
        base_en   = en_cycles;
        base_done = done_cnt;
        @(negedge clk);
        issue_start(12'h020, 13'd2);
        start      = 1'b1;
        start_addr = 12'h030;
        byte_len   = 13'd1;
        @(negedge clk);
        start = 1'b0;
        get_frame("sbz0", bits, gap);
        check("sbz0_data", 32'(bits[8:1]), 32'h5A);
        get_frame("sbz1", bits, gap);
        check("sbz1_data", 32'(bits[8:1]), 32'hC3);
        repeat (10) @(negedge clk);
        #1;
        check("sbz_done_cnt", 32'(done_cnt - base_done), 32'd1);
        check("sbz_en_cnt",   32'(en_cycles - base_en),  32'd2);
        check("sbz_last_addr",32'(last_en_addr),         32'h021);

        // ---------------- reset mid-frame ----------------
        base_done = done_cnt;
        @(negedge clk);
        issue_start(12'h010, 13'd1);
        seen_low = 1'b0;
        for (int n = 0; n < 20 && !seen_low; n++) begin
            @(negedge clk);
            if (txd === 1'b0) seen_low = 1'b1;
        end
        check("rm_started", 32'(seen_low), 32'd1);
        repeat (18) @(negedge clk);
        check("rm_bit3", 32'(txd), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rm_txd",  32'(txd),    32'd1);
        check("rm_busy", 32'(busy),   32'd0);
        check("rm_done", 32'(done),   32'd0);
        check("rm_en",   32'(ram_en), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        #1;
        check("rm_no_done", 32'(done_cnt - base_done), 32'd0);
        @(negedge clk);
        issue_start(12'h010, 13'd1);
        get_frame("rm_new", bits, gap);
        check("rm_new_pattern", 32'(bits[NBITS-1:0]), 32'(sb_exp[NBITS-1:0]));
        @(negedge clk);
        check("rm_new_done", 32'(done), 32'd1);
        @(negedge clk);

        // ---------------- framing of 0x07 / 0x03 ----------------
        @(negedge clk);
        issue_start(12'h040, 13'd2);
        get_frame("pf0", bits, gap);
        check("pf0_data", 32'(bits[8:1]), 32'h07);
`ifdef IO_RAM_TX_PARITY_EN
        check("pf0_parity", 32'(bits[9]), 32'd1);
`endif
        check("pf0_stop", 32'(bits[NBITS-1]), 32'd1);
        get_frame("pf1", bits, gap);
        check("pf1_data", 32'(bits[8:1]), 32'h03);
`ifdef IO_RAM_TX_PARITY_EN
        check("pf1_parity", 32'(bits[9]), 32'd0);
`endif
        check("pf1_stop", 32'(bits[NBITS-1]), 32'd1);
        check("pf1_gap",  32'(gap), 32'd2);
        @(negedge clk);
        check("pf_done", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        check("ram_wr_never", 32'(wr_cycles), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
